int_ctrl: RTL and testbench

Programmable external-interrupt controller between the peripheral bridge and the CP0 `HWInt[5:0]` input. It synchronizes raw device interrupt lines and captures them as per-source edge or level events. It applies a software mask and presents the resulting pending set to CP0 as `hw_int`. The CPU configures and acknowledges it through a 4-word memory-mapped register window on the bridge.

---
 rtl/int_ctrl_if.sv | 31 +++
 rtl/int_ctrl.sv | 172 +++++++++++++++++
 tb/tb_int_ctrl.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/int_ctrl_if.sv
// -----------------------------------------------------------------------------
// int_ctrl_if
//   Register-window bus between the peripheral bridge and the interrupt
//   controller. The bridge is the master; int_ctrl is the slave.
//
//   Signals:
//     we     : register write strobe, one cycle per write
//     addr   : word index into the 4-word window (bridge address bits [3:2])
//     wdata  : write data
//     rdata  : read data, combinational from addr and controller state
// -----------------------------------------------------------------------------
interface int_ctrl_if;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (
    output we,
    output addr,
    output wdata,
    input  rdata
  );

  modport slave (
    input  we,
    input  addr,
    input  wdata,
    output rdata
  );
endinterface : int_ctrl_if

// File: rtl/int_ctrl.sv
// -----------------------------------------------------------------------------
// int_ctrl
//   External-interrupt controller feeding the CP0 HWInt[5:0] input. Raw device
//   lines are (optionally) synchronized, turned into per-source edge or level
//   events, gated by a software mask and presented to the CPU as hw_int.
//
//   Register window (bus.addr):
//     0 PEND : pending bits; write-1 clears edge-mode bits, level bits ignore
//     1 MASK : enable of each source onto hw_int / VEC
//     2 MODE : 1 = edge mode, 0 = level mode
//     3 VEC  : read-only; [31] = any enabled pending, [2:0] = lowest index
//
//   Ports:
//     clk     : clock, all state on the rising edge
//     reset   : asynchronous, active-high reset
//     irq_src : raw device interrupt lines [N_SRC-1:0]
//     bus     : register window, slave side of int_ctrl_if
//     hw_int  : to CP0 HWInt, PEND & MASK
//
//   Parameters:
//     N_SRC   : number of sources, 1..6; unused bits are tied to 0
//
//   Build option:
//     INTC_SYNC_EN : define to put a two-flop synchronizer on every irq_src
//                    line (+2 cycles latency). Leave undefined only when
//                    irq_src is already synchronous to clk.
// -----------------------------------------------------------------------------
module int_ctrl #(
  parameter int N_SRC = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] irq_src,
  int_ctrl_if.slave        bus,
  output logic [5:0]       hw_int
);

  // Word index of each register in the window.
  typedef enum logic [1:0] {
    REG_PEND = 2'd0,
    REG_MASK = 2'd1,
    REG_MODE = 2'd2,
    REG_VEC  = 2'd3
  } reg_addr_e;

  // Bits belonging to implemented sources; everything above N_SRC stays 0.
  localparam logic [5:0] SRC_MASK = 6'((7'd1 << N_SRC) - 7'd1);

  logic [5:0] irq_ext;   // irq_src widened to the 6-bit HWInt space
  logic [5:0] s;         // synchronized source lines
  logic [5:0] prev_q;    // s delayed one cycle, for rise detection
  logic [5:0] rise;
  logic [5:0] pend_q, pend_d;
  logic [5:0] mask_q;
  logic [5:0] mode_q;
  logic [5:0] clr;       // write-1-clear request for PEND this cycle
  logic [5:0] active;    // PEND & MASK
  logic       vec_any;
  logic [2:0] vec_idx;
  logic       wr_pend, wr_mask, wr_mode;
  logic       unused_wdata;

  assign irq_ext = 6'(irq_src) & SRC_MASK;

  // ---------------------------------------------------------------------------
  // Input synchronization
  // ---------------------------------------------------------------------------
`ifdef INTC_SYNC_EN
  logic [5:0] sync_q1, sync_q2;

  // NOTE: sequential state is assigned with non-blocking (<=) so every flop
  // samples the pre-edge values; blocking here would collapse the two stages.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= irq_ext;
      sync_q2 <= sync_q1;
    end
  end

  assign s = sync_q2;
`else
  // Source is already synchronous to clk: feed it straight to edge/level logic.
  assign s = irq_ext;
`endif

  // ---------------------------------------------------------------------------
  // Edge detection. prev_q resets to 0, so a line held high through reset
  // release is seen as exactly one rise once it reaches s.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) prev_q <= '0;
    else       prev_q <= s;
  end

  assign rise = s & ~prev_q;

  // ---------------------------------------------------------------------------
  // Register write decode
  // ---------------------------------------------------------------------------
  assign wr_pend = bus.we && (bus.addr == REG_PEND);
  assign wr_mask = bus.we && (bus.addr == REG_MASK);
  assign wr_mode = bus.we && (bus.addr == REG_MODE);

  assign clr = wr_pend ? bus.wdata[5:0] : 6'd0;

  // Only the low six data bits are meaningful to any register.
  assign unused_wdata = ^bus.wdata[31:6];

  // ---------------------------------------------------------------------------
  // Pending next-state. The mode used is the registered one, so a MODE write
  // changes behaviour from the following edge: edge->level drops the latched
  // bit and tracks s; level->edge keeps whatever PEND held.
  // ---------------------------------------------------------------------------
  // NOTE: pend_d gets a full default before the loop so no path leaves it
  // unassigned; otherwise always_comb would infer a latch.
  always_comb begin
    pend_d = '0;
    for (int i = 0; i < 6; i++) begin
      if (mode_q[i]) begin
        // A rise in the same cycle as a clear wins: the bit stays set.
        pend_d[i] = rise[i] | (pend_q[i] & ~clr[i]);
      end else begin
        pend_d[i] = s[i];
      end
    end
    pend_d = pend_d & SRC_MASK;
  end

  // NOTE: every control/status register is cleared by the asynchronous reset;
  // reset mid-operation must drop all pending state at once, not at an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q <= '0;
      mask_q <= '0;
      mode_q <= '0;
    end else begin
      pend_q <= pend_d;
      if (wr_mask) mask_q <= bus.wdata[5:0] & SRC_MASK;
      if (wr_mode) mode_q <= bus.wdata[5:0] & SRC_MASK;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: masking, priority vector, read mux
  // ---------------------------------------------------------------------------
  assign active = pend_q & mask_q;
  assign hw_int = active;
  assign vec_any = |active;

  // Lowest set index has highest priority; scan downward so it is written last.
  always_comb begin
    vec_idx = 3'd0;
    for (int i = 5; i >= 0; i--) begin
      if (active[i]) vec_idx = 3'(i);
    end
  end

  always_comb begin
    bus.rdata = '0;
    case (bus.addr)
      REG_PEND: bus.rdata = {26'd0, pend_q};
      REG_MASK: bus.rdata = {26'd0, mask_q};
      REG_MODE: bus.rdata = {26'd0, mode_q};
      REG_VEC:  bus.rdata = {vec_any, 28'd0, vec_idx};
      default:  bus.rdata = '0;
    endcase
  end

endmodule : int_ctrl

// File: tb/tb_int_ctrl.sv
// -----------------------------------------------------------------------------
// tb_int_ctrl
//   Directed scenarios followed by randomized traffic for int_ctrl (N_SRC=6).
//   Expected values come from a behavioural model that keeps a history of the
//   sampled irq lines and applies the pending/mask/mode rules per edge.
// -----------------------------------------------------------------------------
module tb_int_ctrl;

`ifdef INTC_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       clk;
  logic       reset;
  logic [5:0] irq;
  logic [5:0] hw_int;

  int_ctrl_if bus ();

  int_ctrl #(.N_SRC(6)) dut (
    .clk     (clk),
    .reset   (reset),
    .irq_src (irq),
    .bus     (bus.slave),
    .hw_int  (hw_int)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // ---------------- reference model ----------------
  logic [5:0] samp[$];   // irq values sampled at edges, newest first
  logic [5:0] m_prev;
  logic [5:0] m_pend;
  logic [5:0] m_mask;
  logic [5:0] m_mode;

  task automatic model_reset();
    samp.delete();
    for (int j = 0; j <= LAT; j++) samp.push_back(6'd0);
    m_prev = '0;
    m_pend = '0;
    m_mask = '0;
    m_mode = '0;
  endtask

  function automatic logic [31:0] model_vec();
    logic [5:0] act;
    act = m_pend & m_mask;
    for (int i = 0; i < 6; i++)
      if (act[i]) return {1'b1, 28'd0, 3'(i)};
    return 32'd0;
  endfunction

  function automatic logic [31:0] model_read(input logic [1:0] a);
    case (a)
      2'd0:    return {26'd0, m_pend};
      2'd1:    return {26'd0, m_mask};
      2'd2:    return {26'd0, m_mode};
      default: return model_vec();
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance the model by one edge using the inputs currently driven, then
  // clock the DUT and compare its outputs.
  task automatic tick();
    logic [5:0] s_e;
    logic [5:0] rise;
    logic [5:0] clr;
    samp.push_front(irq);
    s_e = samp[LAT];
    while (samp.size() > LAT + 1) void'(samp.pop_back());
    rise = s_e & ~m_prev;
    clr  = (bus.we && bus.addr == 2'd0) ? bus.wdata[5:0] : 6'd0;
    for (int i = 0; i < 6; i++) begin
      if (m_mode[i]) m_pend[i] = rise[i] | (m_pend[i] & ~clr[i]);
      else           m_pend[i] = s_e[i];
    end
    m_prev = s_e;
    if (bus.we && bus.addr == 2'd1) m_mask = bus.wdata[5:0];
    if (bus.we && bus.addr == 2'd2) m_mode = bus.wdata[5:0];
    @(posedge clk);
    #1;
    check("model_hw_int", {26'd0, hw_int}, {26'd0, m_pend & m_mask});
    check("model_rdata", bus.rdata, model_read(bus.addr));
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.we = 1'b1; bus.addr = a; bus.wdata = d;
    tick();
    bus.we = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
    bus.addr = a;
    #1;
    check(tag, bus.rdata, exp);
  endtask

  initial begin
    reset = 1'b1;
    irq = '0;
    bus.we = 1'b0; bus.addr = 2'd0; bus.wdata = '0;
    model_reset();

    // Reset state
    #12;
    for (int a = 0; a < 4; a++) rd("reset_rdata", 2'(a), 32'd0);
    check("reset_hw_int", {26'd0, hw_int}, 32'd0);
    @(posedge clk); #3;
    reset = 1'b0;
    @(negedge clk);
    rd("post_reset_pend", 2'd0, 32'd0);

    // Edge pulse on source 2
    wr(2'd1, 32'h3F);
    wr(2'd2, 32'h04);
    irq = 6'b000100;
    tick();
    irq = '0;
    for (int j = 0; j < LAT; j++) begin
      check("edge2_latency", {26'd0, hw_int}, 32'd0);
      tick();
    end
    check("edge2_hw_int", {26'd0, hw_int}, 32'h04);
    rd("edge2_vec", 2'd3, 32'h8000_0002);
    repeat (3) tick();
    check("edge2_persist", {26'd0, hw_int}, 32'h04);
    wr(2'd0, 32'h04);
    check("edge2_cleared", {26'd0, hw_int}, 32'd0);
    rd("edge2_pend_clr", 2'd0, 32'd0);

    // Level mode on source 0
    wr(2'd2, 32'h00);
    wr(2'd1, 32'h01);
    irq = 6'b000001;
    repeat (LAT + 1) tick();
    check("level0_high", {26'd0, hw_int}, 32'h01);
    wr(2'd0, 32'h01);
    check("level0_noclr", {26'd0, hw_int}, 32'h01);
    irq = '0;
    repeat (LAT + 1) tick();
    check("level0_low", {26'd0, hw_int}, 32'd0);

    // Priority vector with sources 1 and 4
    wr(2'd2, 32'h3F);
    wr(2'd1, 32'h3F);
    irq = 6'b010010;
    tick();
    irq = '0;
    repeat (LAT) tick();
    rd("vec_1_4", 2'd3, 32'h8000_0001);
    wr(2'd0, 32'h02);
    rd("vec_4", 2'd3, 32'h8000_0004);
    wr(2'd1, 32'h00);
    rd("vec_masked", 2'd3, 32'd0);
    check("hw_int_masked", {26'd0, hw_int}, 32'd0);
    rd("pend_masked", 2'd0, 32'h10);

    // Rise and write-1-clear of bit 3 on the same edge
    irq = 6'b001000;
    repeat (LAT) tick();
    wr(2'd0, 32'h08);
    rd("set_wins", 2'd0, 32'h18);
    irq = '0;
    tick();
    wr(2'd0, 32'h18);
    rd("clear_after", 2'd0, 32'd0);

    // Asynchronous reset with everything pending
    irq = 6'h3F;
    tick();
    irq = '0;
    repeat (LAT) tick();
    rd("pend_all", 2'd0, 32'h3F);
    wr(2'd1, 32'h3F);
    irq = 6'h20;
    #2 reset = 1'b1;
    model_reset();
    #1;
    check("async_rst_hw_int", {26'd0, hw_int}, 32'd0);
    for (int a = 0; a < 4; a++) rd("async_rst_rdata", 2'(a), 32'd0);
    @(posedge clk); @(posedge clk); #3;
    reset = 1'b0;
    @(negedge clk);
    wr(2'd2, 32'h20);
    wr(2'd1, 32'h20);
    repeat (LAT + 1) tick();
    rd("held_src5_pend", 2'd0, 32'h20);
    check("held_src5_hw_int", {26'd0, hw_int}, 32'h20);
    wr(2'd0, 32'h20);
    repeat (3) tick();
    rd("held_src5_once", 2'd0, 32'd0);
    irq = '0;

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      irq       = 6'($urandom);
      bus.we    = ($urandom_range(0, 2) == 0);
      bus.addr  = 2'($urandom);
      bus.wdata = $urandom;
      tick();
    end
    bus.we = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_int_ctrl
